// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipeline_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef logic [4:0] reg_addr_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-facing signal bundle: stage register fields in, enables/flushes/selects out.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_memread;
    logic [4:0] ex_write_reg;
    logic       mem_regwrite;
    logic       mem_memread;
    logic       mem_memwrite;
    logic       mem_branch;
    logic       mem_zero;
    logic [4:0] mem_write_reg;
    logic       wb_regwrite;
    logic [4:0] wb_write_reg;
    logic       dmem_ready;
    logic       dmem_req;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_write;
    logic       exmem_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic       pcsrc;
    logic [1:0] forward_a;
    logic [1:0] forward_b;

    // The controller is the master: it drives every enable, flush and select.
    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_write_reg,
               mem_regwrite, mem_memread, mem_memwrite, mem_branch, mem_zero,
               mem_write_reg, wb_regwrite, wb_write_reg, dmem_ready,
        output dmem_req, pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, pcsrc,
               forward_a, forward_b
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread, ex_write_reg,
               mem_regwrite, mem_memread, mem_memwrite, mem_branch, mem_zero,
               mem_write_reg, wb_regwrite, wb_write_reg, dmem_ready,
        input  dmem_req, pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush, pcsrc,
               forward_a, forward_b
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Forwarding select for one EX operand; the EX/MEM producer wins over MEM/WB.
module forward_unit
    import pipeline_pkg::*;
(
    input  reg_addr_t  src,
    input  logic       mem_regwrite,
    input  reg_addr_t  mem_write_reg,
    input  logic       wb_regwrite,
    input  reg_addr_t  wb_write_reg,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwrite && (mem_write_reg != REG_ZERO) && (mem_write_reg == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_write_reg != REG_ZERO) && (wb_write_reg == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: forwarding, branch flush, load-use stall and data-memory freeze.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int WAIT_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.master hz,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  mem_timeout
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    state_t            state_reg, state_next;
    logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cycles_reg;
    logic              mem_timeout_reg, mem_timeout_next;

    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic pcsrc, dmem_req;
    logic mem_op, branch_taken, load_use;

    reg_addr_t  ex_src  [2];
    logic [1:0] fwd_sel [2];

    assign ex_src[0] = hz.ex_rs;
    assign ex_src[1] = hz.ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_unit u_fwd (
                .src           (ex_src[gi]),
                .mem_regwrite  (hz.mem_regwrite),
                .mem_write_reg (hz.mem_write_reg),
                .wb_regwrite   (hz.wb_regwrite),
                .wb_write_reg  (hz.wb_write_reg),
                .sel           (fwd_sel[gi])
            );
        end
    endgenerate

    assign mem_op       = hz.mem_memread || hz.mem_memwrite;
    assign branch_taken = hz.mem_branch && hz.mem_zero;
    assign load_use     = hz.ex_memread && (hz.ex_write_reg != REG_ZERO) &&
                          ((hz.ex_write_reg == hz.id_rs) ||
                           (hz.id_uses_rt && (hz.ex_write_reg == hz.id_rt)));

    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        mem_timeout_next = mem_timeout_reg;
        pc_write         = 1'b1;
        ifid_write       = 1'b1;
        idex_write       = 1'b1;
        exmem_write      = 1'b1;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;
        exmem_flush      = 1'b0;
        memwb_flush      = 1'b0;
        pcsrc            = 1'b0;
        dmem_req         = 1'b0;

        case (state_reg)
            RUN: begin
                dmem_req = mem_op;
                if (mem_op && !hz.dmem_ready) begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_write    = 1'b0;
                    exmem_write   = 1'b0;
                    memwb_flush   = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WCNT_W'(1);
                end else if (branch_taken) begin
                    pcsrc       = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                if (hz.dmem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (int'(wait_cnt_reg) + 1 >= WAIT_MAX) begin
                    // Give up: release the pipeline but drop the MEM/WB result.
                    memwb_flush      = 1'b1;
                    mem_timeout_next = 1'b1;
                    state_next       = RUN;
                    wait_cnt_next    = '0;
                end else begin
                    pc_write      = 1'b0;
                    ifid_write    = 1'b0;
                    idex_write    = 1'b0;
                    exmem_write   = 1'b0;
                    memwb_flush   = 1'b1;
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase

        // Reset overrides combinationally so the pipeline is held in bubbles immediately.
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            pcsrc       = 1'b0;
            dmem_req    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= RUN;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
            mem_timeout_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
            if (!pc_write && (stall_cycles_reg != {CNT_W{1'b1}})) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
        end
    end

    assign hz.dmem_req    = dmem_req;
    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.idex_write  = idex_write;
    assign hz.exmem_write = exmem_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_flush = memwb_flush;
    assign hz.pcsrc       = pcsrc;
    assign hz.forward_a   = fwd_sel[0];
    assign hz.forward_b   = fwd_sel[1];
    assign stall_cycles   = stall_cycles_reg;
    assign mem_timeout    = mem_timeout_reg;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Drives write-enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates EX-stage forwarding selects, resolves branches from the EX/MEM branch/zero outputs, detects load-use hazards.
- Freezes the pipeline while a multi-cycle data memory access completes via a req/ready handshake.

Parameters:
- WAIT_MAX, 64, max cycles in MEM_WAIT before timeout abort.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_write_reg  in  5  destination register in EX
- mem_regwrite, mem_memread, mem_memwrite, mem_branch, mem_zero  in  1 each  EX/MEM register outputs
- mem_write_reg  in  5  EX/MEM destination register
- wb_regwrite  in  1  MEM/WB regwrite
- wb_write_reg  in  5  MEM/WB destination register
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory request
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  insert bubble (clear control bits)
- pcsrc  out  1  select branch target
- forward_a, forward_b  out  2 each  00 = regfile, 10 = EX/MEM ALU result, 01 = WB value
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write = 0
- mem_timeout  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered: state, wait_cnt, stall_cycles, mem_timeout. Everything else is combinational from state and inputs.
- Reset (reset = 0, asynchronous): state = RUN, wait_cnt = 0, stall_cycles = 0, mem_timeout = 0. While reset is low, every flush = 1, every write enable = 0, dmem_req = 0, pcsrc = 0.
- Reset mid-MEM_WAIT: the access is abandoned and the controller restarts in RUN.
- Forwarding (any state):
  - forward_a = 10 if mem_regwrite and mem_write_reg != 0 and mem_write_reg == ex_rs.
  - Else forward_a = 01 if wb_regwrite and wb_write_reg != 0 and wb_write_reg == ex_rs.
  - Else forward_a = 00.
  - forward_b is identical using ex_rt. EX/MEM beats MEM/WB.
- Defaults in RUN: all write enables = 1, all flushes = 0, pcsrc = 0.
- Priority in RUN:
  1. Memory access. mem_memread or mem_memwrite gives dmem_req = 1.
     - If dmem_ready is also 1: access completes, no stall.
     - Else: pc_write = ifid_write = idex_write = exmem_write = 0, memwb_flush = 1, next state = MEM_WAIT, wait_cnt = 1.
  2. Branch taken (mem_branch and mem_zero): pcsrc = 1; ifid_flush = idex_flush = exmem_flush = 1. One cycle only, no state change.
  3. Load-use: ex_memread and ex_write_reg != 0 and (ex_write_reg == id_rs, or id_uses_rt and ex_write_reg == id_rt). Then pc_write = ifid_write = 0 and idex_flush = 1 for one cycle. Re-evaluated every cycle.
- Branch and memory op cannot share the MEM stage. Branch-taken suppresses load-use in the same cycle.
- MEM_WAIT:
  - dmem_req = 1. All four write enables = 0, memwb_flush = 1, other flushes = 0.
  - On dmem_ready = 1: enables return to 1 and memwb_flush = 0 in that same cycle (data is captured), next state = RUN, wait_cnt = 0.
  - Else wait_cnt increments. On reaching WAIT_MAX: mem_timeout set (sticky until reset), next state = RUN, and that cycle behaves like completion with memwb_flush = 1 (result discarded).
- stall_cycles increments every cycle pc_write = 0, saturating at all-ones.
- dmem_req never drops while in MEM_WAIT.

Decomposition:
- Shared package (pipeline_pkg):
  - state enum {RUN, MEM_WAIT}
  - forwarding select constants FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10
  - register-zero constant
- One natural sub-module: forward_unit (purely combinational forwarding selects), instantiated twice or once with both operands. Hazard/FSM logic stays in the top.

Test Plan:
- Reset: hold reset = 0 with random inputs → all flushes 1, enables 0, stall_cycles 0. Release → RUN, enables 1.
- Forwarding: mem_regwrite = 1, mem_write_reg = 5, wb_regwrite = 1, wb_write_reg = 5, ex_rs = 5, ex_rt = 5 → forward_a = forward_b = 10. Change mem_write_reg to 0 → 01.
- Load-use: ex_memread = 1, ex_write_reg = 8, id_rs = 8 → one cycle pc_write = 0, ifid_write = 0, idex_flush = 1, stall_cycles +1. Then id_rs = 3 → no stall.
- Branch: mem_branch = 1, mem_zero = 1, simultaneous load-use pattern → pcsrc = 1, three flushes 1, pc_write = 1. mem_zero = 0 → pcsrc = 0, no flush.
- Memory wait: mem_memread = 1, dmem_ready low for 3 cycles then high → 3 frozen cycles with memwb_flush = 1, 4th cycle enables 1, back to RUN, stall_cycles = 3.
- Timeout: WAIT_MAX = 4, dmem_ready held 0 → mem_timeout = 1 after 4 cycles, return to RUN. Flag stays 1 until reset = 0.
